// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline stage.
// A main register drives the outputs, and a skid register absorbs the one
// entry that can arrive while the downstream stage is stalling. ready_out
// depends only on registered state, so ready_in never reaches it
// combinationally. Control bits are forced to zero on every bubble, which
// keeps side-effecting controls such as MemWrite from firing on a dead slot.
// Optional feature: define PIPE_STAGE_REG_PERF_CNT_EN to add the stall_cnt
// port and its saturating downstream-stall counter (parameter CNT_W).
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 3
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic              mainValid;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              acceptIn;
  logic              mainFree;

  // The stage can take an entry whenever the skid slot is empty. skidValid
  // is a flop, so ready_out is registered as well.
  assign ready_out = ~skidValid;
  assign acceptIn  = valid_in & ready_out;
  // Main can be overwritten this edge if it is empty or its entry is leaving.
  assign mainFree  = ~mainValid | ready_in;

  assign valid_out = mainValid;
  assign ctrl_out  = mainValid ? mainCtrl : '0;
  assign data_out  = mainData;

  // Main and skid update together. Flush overrides every move. When main
  // frees up, it refills from skid first (to keep ordering) or else from the
  // input. If main is stuck, a new arrival parks in skid.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      mainData  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      skidData  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
    end else if (mainFree) begin
      if (skidValid) begin
        mainValid <= 1'b1;
        mainCtrl  <= skidCtrl;
        mainData  <= skidData;
        skidValid <= acceptIn;
        if (acceptIn) begin
          skidCtrl <= ctrl_in;
          skidData <= data_in;
        end else begin
          skidCtrl <= '0;
        end
      end else begin
        mainValid <= acceptIn;
        if (acceptIn) begin
          mainCtrl <= ctrl_in;
          mainData <= data_in;
        end else begin
          mainCtrl <= '0;
        end
      end
    end else if (acceptIn) begin
      skidValid <= 1'b1;
      skidCtrl  <= ctrl_in;
      skidData  <= data_in;
    end
  end

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  assign stall_cnt = stallCnt;

  // Count the cycles in which a valid entry is presented but refused. The
  // counter saturates and survives flush, so only reset clears it.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (mainValid && !ready_in && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed, table-driven bench for pipe_stage_reg.
// Each table row gives the inputs for one cycle and the outputs expected just
// after the following rising edge. Hand-written sequences cover reset and,
// when PIPE_STAGE_REG_PERF_CNT_EN is defined, the stall counter.
module tb_pipe_stage_reg;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 3;
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  localparam int CNT_W = 4;
`endif

  logic              CLK;
  logic              rst;
  logic              valid_in;
  logic              ready_out;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              flush;
  logic              valid_out;
  logic              ready_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic              flush;
    logic              validIn;
    logic              readyIn;
    logic [CTRL_W-1:0] ctrlIn;
    logic [DATA_W-1:0] dataIn;
    logic              expValid;
    logic              expReady;
    logic [CTRL_W-1:0] expCtrl;
    logic [DATA_W-1:0] expData;
  } vec_t;

  vec_t vecs[$];

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .ctrl_in(ctrl_in),
    .data_in(data_in),
    .flush(flush),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .ctrl_out(ctrl_out),
    .data_out(data_out)
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic fl, input logic vi, input logic ri,
                               input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    flush    = fl;
    valid_in = vi;
    ready_in = ri;
    ctrl_in  = c;
    data_in  = d;
  endtask

  task automatic checkOutput(input string name, input logic eV, input logic eR,
                             input logic [CTRL_W-1:0] eC, input logic [DATA_W-1:0] eD);
    vecCount++;
    if (valid_out !== eV || ready_out !== eR || ctrl_out !== eC || data_out !== eD) begin
      missCount++;
      $display("[TB] FAIL %s: got valid=%b ready=%b ctrl=%h data=%h, want valid=%b ready=%b ctrl=%h data=%h",
               name, valid_out, ready_out, ctrl_out, data_out, eV, eR, eC, eD);
    end
  endtask

  task automatic addVec(input logic fl, input logic vi, input logic ri,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic eV, input logic eR,
                        input logic [CTRL_W-1:0] eC, input logic [DATA_W-1:0] eD);
    vec_t v;
    v.flush = fl; v.validIn = vi; v.readyIn = ri; v.ctrlIn = c; v.dataIn = d;
    v.expValid = eV; v.expReady = eR; v.expCtrl = eC; v.expData = eD;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DATA_W-1:0] bigG;
    bigG = 69'h10_0000_0000_0000_0010;

    // Pass-through at full rate: each entry shows up one edge after acceptance.
    for (int i = 1; i <= 8; i++)
      addVec(0, 1, 1, 3'd1, DATA_W'(i), 1, 1, 3'd1, DATA_W'(i));
    addVec(0, 0, 1, 3'd0, '0,      0, 1, 3'd0, 69'h8);
    // Backpressure: A to main, B to skid, C refused, then drained in order.
    addVec(0, 1, 0, 3'd2, 69'hA,   1, 1, 3'd2, 69'hA);
    addVec(0, 1, 0, 3'd3, 69'hB,   1, 0, 3'd2, 69'hA);
    addVec(0, 1, 0, 3'd4, 69'hC,   1, 0, 3'd2, 69'hA);
    addVec(0, 1, 1, 3'd4, 69'hC,   1, 1, 3'd3, 69'hB);
    addVec(0, 1, 1, 3'd4, 69'hC,   1, 1, 3'd4, 69'hC);
    addVec(0, 0, 1, 3'd0, '0,      0, 1, 3'd0, 69'hC);
    // Flush with both slots full and a new entry offered.
    addVec(0, 1, 0, 3'd5, 69'hD,   1, 1, 3'd5, 69'hD);
    addVec(0, 1, 0, 3'd6, 69'hE,   1, 0, 3'd5, 69'hD);
    addVec(1, 1, 0, 3'd7, 69'hF,   0, 1, 3'd0, 69'hD);
    addVec(0, 0, 1, 3'd7, 69'hF,   0, 1, 3'd0, 69'hD);
    // Bubbles carrying all-ones control must never show control bits.
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 0, 3'd7, 69'h77, 0, 1, 3'd0, 69'hD);
    // Single-cycle stall in a stream, with a wide payload using the top bit.
    addVec(0, 1, 1, 3'd1, bigG,    1, 1, 3'd1, bigG);
    addVec(0, 1, 0, 3'd2, 69'h11,  1, 0, 3'd1, bigG);
    addVec(0, 1, 1, 3'd3, 69'h12,  1, 1, 3'd2, 69'h11);
    addVec(0, 1, 1, 3'd3, 69'h12,  1, 1, 3'd3, 69'h12);
    addVec(0, 0, 1, 3'd0, '0,      0, 1, 3'd0, 69'h12);
    // Flush beats an accept into an empty main register.
    addVec(1, 1, 1, 3'd6, 69'h13,  0, 1, 3'd0, 69'h12);
    addVec(0, 0, 1, 3'd0, '0,      0, 1, 3'd0, 69'h12);

    // Reset, then check the reset state before any stimulus.
    applyStimulus(0, 0, 0, '0, '0);
    rst = 1'b0;
    #12;
    checkOutput("reset_state", 0, 1, 3'd0, '0);
    @(negedge CLK);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].flush, vecs[i].validIn, vecs[i].readyIn, vecs[i].ctrlIn, vecs[i].dataIn);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expReady,
                  vecs[i].expCtrl, vecs[i].expData);
      @(negedge CLK);
    end

    // Asynchronous reset with two entries held: outputs clear with no edge.
    applyStimulus(0, 1, 0, 3'd5, 69'h21);
    @(posedge CLK); #1;
    applyStimulus(0, 1, 0, 3'd6, 69'h22);
    @(posedge CLK); #1;
    checkOutput("mid_reset_loaded", 1, 0, 3'd5, 69'h21);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_async", 0, 1, 3'd0, '0);
    @(negedge CLK);
    rst = 1'b1;
    applyStimulus(0, 1, 1, 3'd2, 69'h23);
    @(posedge CLK); #1;
    checkOutput("first_after_reset", 1, 1, 3'd2, 69'h23);
    applyStimulus(0, 0, 1, '0, '0);
    @(posedge CLK); #1;
    checkOutput("no_stale_skid", 0, 1, 3'd0, 69'h23);

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    // Stall counter saturates at 15, survives flush, clears on reset.
    @(negedge CLK);
    applyStimulus(0, 1, 0, 3'd1, 69'h30);
    @(posedge CLK); #1;
    applyStimulus(0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) @(posedge CLK);
    #1;
    vecCount++;
    if (stall_cnt !== 4'd15) begin
      missCount++;
      $display("[TB] FAIL stall_sat: got %0d want 15", stall_cnt);
    end
    @(negedge CLK);
    applyStimulus(1, 0, 0, '0, '0);
    @(posedge CLK); #1;
    applyStimulus(0, 0, 0, '0, '0);
    @(posedge CLK); #1;
    vecCount++;
    if (stall_cnt !== 4'd15) begin
      missCount++;
      $display("[TB] FAIL stall_flush: got %0d want 15", stall_cnt);
    end
    rst = 1'b0;
    #1;
    vecCount++;
    if (stall_cnt !== 4'd0) begin
      missCount++;
      $display("[TB] FAIL stall_reset: got %0d want 0", stall_cnt);
    end
    @(negedge CLK);
    rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 69, width of the payload held through the stage (ALU result, store data, dest reg).
REQ-002 Parameter CTRL_W, default 3, width of control bits (e.g. MemWrite, RegWrite, MemtoReg) forced to zero on any bubble.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  upstream holds a valid entry.
REQ-007 ready_out  output  1  stage can accept an entry this cycle.
REQ-008 ctrl_in  input  CTRL_W  upstream control bits.
REQ-009 data_in  input  DATA_W  upstream payload.
REQ-010 flush  input  1  synchronous kill of every entry held or offered.
REQ-011 valid_out  output  1  stage presents a valid entry downstream.
REQ-012 ready_in  input  1  downstream accepts the presented entry.
REQ-013 ctrl_out  output  CTRL_W  control bits of the presented entry; all zero when valid_out=0.
REQ-014 data_out  output  DATA_W  payload of the presented entry.
REQ-015 stall_cnt  output  CNT_W  downstream-stall cycle count (present only with PIPE_STAGE_REG_PERF_CNT_EN).

Function
REQ-016 The stage SHALL hold two entries, main (drives outputs) and skid, each with a valid bit, ctrl and data register.
REQ-017 The stage SHALL accept an entry when valid_in=1 and ready_out=1, and release one when valid_out=1 and ready_in=1.
REQ-018 ready_out SHALL be a registered signal equal to NOT skid valid; no combinational path from ready_in to ready_out.
REQ-019 An entry accepted into an empty or draining main register SHALL appear on the outputs exactly 1 cycle later.
REQ-020 An entry accepted while main is occupied and not draining SHALL be written to skid.
REQ-021 When main drains and skid is valid, skid SHALL move to main the same edge; any simultaneous accept SHALL then go to skid.
REQ-022 Entries SHALL leave in acceptance order, never duplicated or dropped except by flush; sustained throughput 1 entry/cycle.
REQ-023 ctrl_out SHALL be gated to zero whenever valid_out=0; data_out holds its last value when invalid.
REQ-024 flush=1 SHALL clear both valid bits and both ctrl registers at the next edge, discard any entry accepted that cycle, and leave ready_out=1.
REQ-025 flush SHALL override every simultaneous accept, drain or skid-to-main move.

Reset
REQ-026 rst=0 SHALL asynchronously clear both valid bits, ctrl, data and stall_cnt to zero, giving valid_out=0, ctrl_out=0, data_out=0, ready_out=1.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; first acceptance is possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro PIPE_STAGE_REG_PERF_CNT_EN defined: stall_cnt port present, increments by 1 each cycle with valid_out=1 and ready_in=0, saturates at all ones, cleared only by reset (not flush).
REQ-029 Macro undefined: stall_cnt port and counter logic are absent; all other behaviour identical.

Verification
REQ-030 Pass-through: ready_in=1, valid_in=1 with data 0x1..0x8 on 8 consecutive cycles -> valid_out=1 for 8 cycles, data_out 0x1..0x8 each 1 cycle later, ready_out=1 throughout.
REQ-031 Backpressure: entries A, B, C offered, ready_in=0 from A's acceptance -> A on outputs, B in skid, ready_out=0, C held upstream; ready_in=1 -> A, B, C delivered in order, no loss.
REQ-032 Flush: both entries valid, flush=1 with valid_in=1 ctrl_in=3'b111 -> next cycle valid_out=0, ctrl_out=3'b000, ready_out=1, offered entry never emitted.
REQ-033 Bubble gating: valid_in=0 with ctrl_in=3'b111 for 5 cycles -> ctrl_out stays 3'b000, valid_out=0.
REQ-034 Reset mid-operation: rst=0 between edges with two entries held -> outputs zero immediately without a clock edge, ready_out=1.
REQ-035 Counter (macro on, CNT_W=4): valid_out=1, ready_in=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves it at 15; rst=0 clears to 0.
